gpio_pad_bridge: RTL and testbench



---
 rtl/gpio_pad_bridge_if.sv | 22 ++
 rtl/gpio_pad_bridge.sv | 145 ++++++++++++++
 tb/tb_gpio_pad_bridge.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/gpio_pad_bridge_if.sv
// Wishbone classic slave bundle shared by the pad bridge and its master.
// Signal names follow the Caravel management bus, seen from the slave.
interface gpio_pad_bridge_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_adr_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/gpio_pad_bridge.sv
// Wishbone pad bridge: output/direction registers, input synchronizer and, when
// GPIO_EDGE_CAPTURE_EN is defined, sticky W1C rising-edge capture per pad.
module gpio_pad_bridge #(
  parameter int unsigned NUM_PADS    = 38,
  parameter logic [31:0] BASE_ADDR   = 32'h3000_1000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_ni,
  gpio_pad_bridge_if.slave    wb,
  input  logic [NUM_PADS-1:0] io_in,
  output logic [NUM_PADS-1:0] io_out,
  output logic [NUM_PADS-1:0] io_oeb,
  output logic [NUM_PADS-1:0] gpio_sync_o
);
  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StAck  = 1'b1;

  logic [0:0]          state_q, state_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [NUM_PADS-1:0] out_q, out_d, oeb_q, oeb_d;
  logic [NUM_PADS-1:0] sync_q [SYNC_STAGES];
  logic [NUM_PADS-1:0] sync_d [SYNC_STAGES];
  logic [NUM_PADS-1:0] edge_bits;

  logic        hit, accept;
  logic [2:0]  word;
  logic [31:0] byte_mask, rd_word;
  logic [63:0] out_ext, oeb_ext, in_ext, edge_ext;
  logic [1:0]  unused_adr;

  // Merge a 32-bit byte-masked write into the LO or HI half; bits past the pad
  // count fall off the top.
  function automatic logic [NUM_PADS-1:0] wr_merge(input logic [NUM_PADS-1:0] cur,
                                                   input logic hi_word,
                                                   input logic [31:0] data,
                                                   input logic [31:0] mask);
    logic [63:0] ext;
    ext = 64'(cur);
    if (hi_word) ext[63:32] = (ext[63:32] & ~mask) | (data & mask);
    else         ext[31:0]  = (ext[31:0] & ~mask) | (data & mask);
    return ext[NUM_PADS-1:0];
  endfunction

  assign unused_adr = wb.wbs_adr_i[1:0];
  assign hit    = wb.wbs_adr_i[31:5] == BASE_ADDR[31:5];
  assign accept = (state_q == StIdle) & wb.wbs_cyc_i & wb.wbs_stb_i & hit;
  assign word   = wb.wbs_adr_i[4:2];

  always_comb begin
    for (int b = 0; b < 4; b++) byte_mask[8*b +: 8] = {8{wb.wbs_sel_i[b]}};
  end

  assign out_ext  = 64'(out_q);
  assign oeb_ext  = 64'(oeb_q);
  assign in_ext   = 64'(gpio_sync_o);
  assign edge_ext = 64'(edge_bits);

  always_comb begin
    rd_word = '0;
    case (word)
      3'd0:    rd_word = out_ext[31:0];
      3'd1:    rd_word = out_ext[63:32];
      3'd2:    rd_word = oeb_ext[31:0];
      3'd3:    rd_word = oeb_ext[63:32];
      3'd4:    rd_word = in_ext[31:0];
      3'd5:    rd_word = in_ext[63:32];
      3'd6:    rd_word = edge_ext[31:0];
      default: rd_word = edge_ext[63:32];
    endcase
  end

  // rdata only holds a value during the ack cycle, so dat_o is zero otherwise.
  always_comb begin
    state_d = StIdle;
    rdata_d = '0;
    out_d   = out_q;
    oeb_d   = oeb_q;
    if (accept) begin
      state_d = StAck;
      rdata_d = rd_word;
      if (wb.wbs_we_i) begin
        case (word[2:1])
          2'b00:   out_d = wr_merge(out_q, word[0], wb.wbs_dat_i, byte_mask);
          2'b01:   oeb_d = wr_merge(oeb_q, word[0], wb.wbs_dat_i, byte_mask);
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    sync_d[0] = io_in;
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= StIdle;
      rdata_q <= '0;
      out_q   <= '0;
      oeb_q   <= '1;
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      out_q   <= out_d;
      oeb_q   <= oeb_d;
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
    end
  end

`ifdef GPIO_EDGE_CAPTURE_EN
  logic [NUM_PADS-1:0] prev_q, edge_q, edge_d, edge_clr;

  always_comb begin
    edge_clr = '0;
    if (accept && wb.wbs_we_i && word[2:1] == 2'b11) begin
      edge_clr = wr_merge('0, word[0], wb.wbs_dat_i, byte_mask);
    end
    // A fresh rising edge beats a simultaneous clear.
    edge_d = (edge_q & ~edge_clr) | (gpio_sync_o & ~prev_q);
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      prev_q <= '0;
      edge_q <= '0;
    end else begin
      prev_q <= gpio_sync_o;
      edge_q <= edge_d;
    end
  end

  assign edge_bits = edge_q;
`else
  assign edge_bits = '0;
`endif

  assign gpio_sync_o  = sync_q[SYNC_STAGES-1];
  assign io_out       = out_q;
  assign io_oeb       = oeb_q;
  assign wb.wbs_ack_o = state_q == StAck;
  assign wb.wbs_dat_o = rdata_q;
endmodule

// File: tb/tb_gpio_pad_bridge.sv
// Bench for gpio_pad_bridge: register table, decode misses, back-to-back strobes,
// reset during ack, input synchronizer latency and W1C edge capture.
module tb_gpio_pad_bridge;
  localparam int NP = 38;
`ifdef GPIO_EDGE_CAPTURE_EN
  localparam bit EdgeEn = 1'b1;
`else
  localparam bit EdgeEn = 1'b0;
`endif
  localparam logic [63:0] OebRst = 64'h3F_FFFF_FFFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [NP-1:0] io_in, io_out, io_oeb, gpio_sync;
  gpio_pad_bridge_if bus();

  gpio_pad_bridge #(.NUM_PADS(NP)) dut (
    .wb_clk_i   (clk),
    .wb_rst_ni  (rst_n),
    .wb         (bus),
    .io_in      (io_in),
    .io_out     (io_out),
    .io_oeb     (io_oeb),
    .gpio_sync_o(gpio_sync)
  );

  typedef struct {
    string       name;
    logic [31:0] addr;
    bit          we;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic [63:0] exp_out;
    logic [63:0] exp_oeb;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] exp_q[$];
  int          tests = 0;
  int          fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input string name, input logic [31:0] off, input bit we,
                     input logic [3:0] sel, input logic [31:0] wd, input logic [31:0] rd,
                     input logic [63:0] eo, input logic [63:0] eb);
    vec_t v;
    v.name = name; v.addr = 32'h3000_1000 + off; v.we = we; v.sel = sel;
    v.wdata = wd; v.exp_rd = rd; v.exp_out = eo; v.exp_oeb = eb;
    vecs.push_back(v);
  endtask

  task automatic bus_idle();
    bus.wbs_stb_i = 1'b0; bus.wbs_cyc_i = 1'b0; bus.wbs_we_i = 1'b0;
    bus.wbs_sel_i = 4'h0; bus.wbs_dat_i = '0;   bus.wbs_adr_i = '0;
  endtask

  task automatic bus_drive(input logic [31:0] addr, input bit we, input logic [3:0] sel,
                           input logic [31:0] wd);
    bus.wbs_adr_i = addr; bus.wbs_we_i = we; bus.wbs_sel_i = sel; bus.wbs_dat_i = wd;
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1;
  endtask

  // Called just after a negedge; returns on the negedge after the ack has dropped.
  task automatic wb_access(input string name, input logic [31:0] addr, input bit we,
                           input logic [3:0] sel, input logic [31:0] wd, input bit chk_rd,
                           input logic [31:0] exp_rd, input bit chk_pads,
                           input logic [63:0] exp_out, input logic [63:0] exp_oeb);
    logic [31:0] exp;
    if (chk_rd) exp_q.push_back(exp_rd);
    bus_drive(addr, we, sel, wd);
    @(posedge clk); #1;
    check({name, " ack"}, 64'(bus.wbs_ack_o), 64'd1);
    if (chk_rd) begin
      exp = exp_q.pop_front();
      if (bus.wbs_ack_o) check({name, " rdata"}, 64'(bus.wbs_dat_o), 64'(exp));
    end
    if (chk_pads) begin
      check({name, " io_out"}, 64'(io_out), exp_out);
      check({name, " io_oeb"}, 64'(io_oeb), exp_oeb);
    end
    @(negedge clk);
    bus_idle();
    @(posedge clk); #1;
    check({name, " ack drop"}, 64'(bus.wbs_ack_o), 64'd0);
    check({name, " dat idle"}, 64'(bus.wbs_dat_o), 64'd0);
    @(negedge clk);
  endtask

  task automatic rd(input string name, input logic [31:0] off, input logic [31:0] exp);
    wb_access(name, 32'h3000_1000 + off, 1'b0, 4'hF, '0, 1'b1, exp, 1'b0, '0, '0);
  endtask

  task automatic wr(input string name, input logic [31:0] off, input logic [31:0] d);
    wb_access(name, 32'h3000_1000 + off, 1'b1, 4'hF, d, 1'b0, '0, 1'b0, '0, '0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] miss_addr [2];
    logic [31:0] exp;
    int          acks;

    bus_idle();
    io_in = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset io_oeb", 64'(io_oeb), OebRst);
    check("reset io_out", 64'(io_out), 64'd0);
    check("reset ack", 64'(bus.wbs_ack_o), 64'd0);
    check("reset dat", 64'(bus.wbs_dat_o), 64'd0);
    check("reset sync", 64'(gpio_sync), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    add("rd_oeb_lo",    32'h08, 0, 4'hF, 32'h0,         32'hFFFF_FFFF, 64'h0,             OebRst);
    add("rd_oeb_hi",    32'h0C, 0, 4'hF, 32'h0,         32'h0000_003F, 64'h0,             OebRst);
    add("rd_out_lo",    32'h00, 0, 4'hF, 32'h0,         32'h0,         64'h0,             OebRst);
    add("wr_out_lo_b01", 32'h00, 1, 4'b0011, 32'hA5A5_A5A5, 32'h0,     64'h00_0000_A5A5,  OebRst);
    add("rd_out_lo",    32'h00, 0, 4'hF, 32'h0,         32'h0000_A5A5, 64'h00_0000_A5A5,  OebRst);
    add("wr_out_lo_b23", 32'h00, 1, 4'b1100, 32'h5A5A_0000, 32'h0,     64'h00_5A5A_A5A5,  OebRst);
    add("wr_out_hi",    32'h04, 1, 4'hF, 32'hFFFF_FFFF, 32'h0,         64'h3F_5A5A_A5A5,  OebRst);
    add("rd_out_hi",    32'h04, 0, 4'hF, 32'h0,         32'h0000_003F, 64'h3F_5A5A_A5A5,  OebRst);
    add("wr_oeb_lo",    32'h08, 1, 4'b1100, 32'h1234_5678, 32'h0,      64'h3F_5A5A_A5A5,
        64'h3F_1234_FFFF);
    add("rd_oeb_lo",    32'h08, 0, 4'hF, 32'h0,         32'h1234_FFFF, 64'h3F_5A5A_A5A5,
        64'h3F_1234_FFFF);
    add("wr_oeb_hi",    32'h0C, 1, 4'b0001, 32'h0,      32'h0,         64'h3F_5A5A_A5A5,
        64'h00_1234_FFFF);
    add("wr_out_hi_b1", 32'h04, 1, 4'b0010, 32'h0,      32'h0,         64'h3F_5A5A_A5A5,
        64'h00_1234_FFFF);
    add("wr_in_lo_ro",  32'h10, 1, 4'hF, 32'hFFFF_FFFF, 32'h0,         64'h3F_5A5A_A5A5,
        64'h00_1234_FFFF);
    add("rd_in_lo",     32'h10, 0, 4'hF, 32'h0,         32'h0,         64'h3F_5A5A_A5A5,
        64'h00_1234_FFFF);
    add("rd_edge_lo",   32'h18, 0, 4'hF, 32'h0,         32'h0,         64'h3F_5A5A_A5A5,
        64'h00_1234_FFFF);
    add("rd_out_lo2",   32'h00, 0, 4'hF, 32'h0,         32'h5A5A_A5A5, 64'h3F_5A5A_A5A5,
        64'h00_1234_FFFF);
    add("rd_out_hi2",   32'h04, 0, 4'hF, 32'h0,         32'h0000_003F, 64'h3F_5A5A_A5A5,
        64'h00_1234_FFFF);
    add("rd_oeb_hi2",   32'h0C, 0, 4'hF, 32'h0,         32'h0,         64'h3F_5A5A_A5A5,
        64'h00_1234_FFFF);

    foreach (vecs[i]) begin
      wb_access(vecs[i].name, vecs[i].addr, vecs[i].we, vecs[i].sel, vecs[i].wdata,
                !vecs[i].we, vecs[i].exp_rd, 1'b1, vecs[i].exp_out, vecs[i].exp_oeb);
    end

    // Out-of-window strobes must stay silent.
    miss_addr[0] = 32'h3000_1020;
    miss_addr[1] = 32'h3000_0000;
    for (int m = 0; m < 2; m++) begin
      bus_drive(miss_addr[m], 1'b0, 4'hF, '0);
      for (int c = 0; c < 3; c++) begin
        @(posedge clk); #1;
        check($sformatf("miss%0d ack c%0d", m, c), 64'(bus.wbs_ack_o), 64'd0);
        check($sformatf("miss%0d dat c%0d", m, c), 64'(bus.wbs_dat_o), 64'd0);
      end
      @(negedge clk);
      bus_idle();
    end

    // Held strobe: acked every other cycle.
    acks = 0;
    for (int k = 0; k < 3; k++) exp_q.push_back(32'h5A5A_A5A5);
    bus_drive(32'h3000_1000, 1'b0, 4'hF, '0);
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      check($sformatf("burst ack c%0d", c), 64'(bus.wbs_ack_o), 64'((c % 2) == 0));
      if (bus.wbs_ack_o && exp_q.size() > 0) begin
        acks++;
        exp = exp_q.pop_front();
        check($sformatf("burst rdata c%0d", c), 64'(bus.wbs_dat_o), 64'(exp));
      end
    end
    check("burst ack count", 64'(acks), 64'd3);
    @(negedge clk);
    bus_idle();
    @(negedge clk);

    // Reset during the ack of a write to OEB_LO.
    bus_drive(32'h3000_1008, 1'b1, 4'hF, 32'h0);
    @(posedge clk); #1;
    check("rst_mid ack", 64'(bus.wbs_ack_o), 64'd1);
    check("rst_mid oeb committed", 64'(io_oeb), 64'h0);
    rst_n = 1'b0;
    #1;
    check("rst_mid ack drop", 64'(bus.wbs_ack_o), 64'd0);
    check("rst_mid dat", 64'(bus.wbs_dat_o), 64'd0);
    check("rst_mid oeb", 64'(io_oeb), OebRst);
    check("rst_mid out", 64'(io_out), 64'd0);
    bus_idle();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rd("post_rst oeb_lo", 32'h08, 32'hFFFF_FFFF);
    rd("post_rst out_lo", 32'h00, 32'h0);

    // Synchronizer latency on pad 33.
    io_in[33] = 1'b1;
    @(posedge clk); #1;
    check("sync33 edge1", 64'(gpio_sync[33]), 64'd0);
    @(posedge clk); #1;
    check("sync33 edge2", 64'(gpio_sync[33]), 64'd1);
    @(negedge clk);
    rd("rd_in_hi", 32'h14, 32'h2);
    rd("rd_in_lo_zero", 32'h10, 32'h0);
    rd("rd_edge_hi", 32'h1C, EdgeEn ? 32'h2 : 32'h0);
    wr("clr_edge_hi", 32'h1C, 32'h2);
    rd("rd_edge_hi_clr", 32'h1C, 32'h0);

    // W1C committed on the edge where gpio_sync[0] rises.
    io_in[0] = 1'b1;
    @(negedge clk);
    wr("w1c_on_rise", 32'h18, 32'h1);
    rd("edge_lo after w1c_on_rise", 32'h18, EdgeEn ? 32'h1 : 32'h0);
    wr("w1c_clear", 32'h18, 32'h1);
    rd("edge_lo cleared", 32'h18, 32'h0);

    // W1C committed on the edge where the rise is detected: set still wins.
    io_in[0] = 1'b0;
    repeat (4) @(negedge clk);
    io_in[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    wr("w1c_collide", 32'h18, 32'h1);
    rd("edge_lo after collide", 32'h18, EdgeEn ? 32'h1 : 32'h0);
    wr("w1c_clear2", 32'h18, 32'h1);
    rd("edge_lo cleared2", 32'h18, 32'h0);

    check("scoreboard drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
